// File: rtl/tick_divider_pkg.sv
// -----------------------------------------------------------------------------
// tick_divider_pkg
//
// Shared definitions for the tick divider:
//   state_t       : run-control FSM encoding (IDLE, RUN, DONE)
//   CLK_HZ_50M    : nominal system clock frequency in Hz
//   DIV_100HZ     : divisor that turns a 50 MHz clock into a 100 Hz tick
//   TICK_RATE_HZ  : tick rate implied by the two constants above. It is used to
//                   derive the reset divisor for any clock frequency.
// -----------------------------------------------------------------------------
package tick_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned CLK_HZ_50M   = 50_000_000;
  localparam int unsigned DIV_100HZ    = 500_000;
  localparam int unsigned TICK_RATE_HZ = CLK_HZ_50M / DIV_100HZ;

endpackage

// File: rtl/tick_divider.sv
// -----------------------------------------------------------------------------
// tick_divider
//
// Programmable period timer. Once started, Count runs 0..Div-1 on every enabled
// cycle. When Count reaches its terminal value, it wraps, and a registered
// one-cycle Tick is issued. The period is therefore exactly Div enabled cycles.
// The timer has a periodic mode and a one-shot mode. In one-shot mode the block
// parks in DONE after the first Tick.
//
// Parameters
//   CLK_HZ       input clock frequency in Hz
//   WIDTH        counter / divisor width in bits
//   DEFAULT_DIV  divisor loaded at reset (defaults to a 100 Hz tick)
//
// Ports
//   Clock        system clock, all logic on its rising edge
//   Resetn       synchronous active-low reset
//   En           count enable; low freezes Count and the FSM state
//   Start        pulse: start, or restart, a timing run
//   Stop         pulse: abort the run and return to IDLE (wins over Start)
//   Mode         0 = periodic, 1 = one-shot; sampled only on an accepted Start
//   Div_in       new divisor value (0 is treated as 1)
//   Div_load     pulse: capture Div_in
//   Tick         one-cycle pulse at the end of each period
//   Count        current count, 0..Div-1
//   Busy         high in RUN
//   Done         high in DONE (one-shot finished)
//   Div_pending  high while a divisor loaded during RUN waits to be applied
// -----------------------------------------------------------------------------
module tick_divider
  import tick_divider_pkg::*;
#(
  parameter int unsigned CLK_HZ      = CLK_HZ_50M,
  parameter int unsigned WIDTH       = 26,
  parameter int unsigned DEFAULT_DIV = CLK_HZ / TICK_RATE_HZ
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             En,
  input  logic             Start,
  input  logic             Stop,
  input  logic             Mode,
  input  logic [WIDTH-1:0] Div_in,
  input  logic             Div_load,
  output logic             Tick,
  output logic [WIDTH-1:0] Count,
  output logic             Busy,
  output logic             Done,
  output logic             Div_pending
);

  // ---------------------------------------------------------------------------
  // Elaboration-time sanity: the reset divisor must fit in the counter.
  // ---------------------------------------------------------------------------
  if (WIDTH < 64) begin : g_width_check
    if ((64'd1 << WIDTH) <= 64'(DEFAULT_DIV)) begin : g_width_too_small
      $error("tick_divider: WIDTH=%0d cannot represent DEFAULT_DIV=%0d",
             WIDTH, DEFAULT_DIV);
    end
  end

  // A divisor of 0 has no meaningful period. It is folded onto 1, which gives
  // a Tick on every enabled cycle.
  localparam logic [WIDTH-1:0] RESET_DIV =
    (DEFAULT_DIV == 0) ? WIDTH'(1) : WIDTH'(DEFAULT_DIV);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           state_q,       state_d;
  logic [WIDTH-1:0] count_q,       count_d;
  logic             tick_q,        tick_d;
  logic [WIDTH-1:0] div_q,         div_d;          // active divisor
  logic [WIDTH-1:0] pend_div_q,    pend_div_d;     // shadow divisor
  logic             div_pending_q, div_pending_d;
  logic             mode_q,        mode_d;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] div_in_safe;
  logic             terminal;
  logic             wrap;
  logic             apply_point;
  logic             load_has;
  logic [WIDTH-1:0] load_val;

  always_comb begin
    div_in_safe = (Div_in == '0) ? WIDTH'(1) : Div_in;
    terminal    = (count_q == (div_q - WIDTH'(1)));
    wrap        = (state_q == RUN) && En && terminal;

    // A period boundary is the only safe place to swap divisors while running.
    // Start and Stop both restart or clear the count, so they qualify as well.
    apply_point = Stop || Start || wrap;

    // A Div_load in the same cycle as an apply point takes effect at once. In
    // that case the new value overrides any older pending value.
    load_has    = Div_load || div_pending_q;
    load_val    = Div_load ? div_in_safe : pend_div_q;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    tick_d        = 1'b0;
    div_d         = div_q;
    pend_div_d    = pend_div_q;
    div_pending_d = div_pending_q;
    mode_d        = mode_q;

    // Run control. Stop has priority over Start. Both are honoured even while
    // En is low.
    if (Stop) begin
      state_d = IDLE;
      count_d = '0;
    end else if (Start) begin
      state_d = RUN;
      count_d = '0;
      mode_d  = Mode;
    end else if ((state_q == RUN) && En) begin
      if (terminal) begin
        count_d = '0;
        tick_d  = 1'b1;
        if (mode_q) begin
          state_d = DONE;
        end
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end

    // Divisor update. Outside RUN there is no period in flight, so a load is
    // applied immediately. Inside RUN it is parked in the shadow register.
    if (state_q != RUN) begin
      if (Div_load) begin
        div_d = div_in_safe;
      end
      div_pending_d = 1'b0;
    end else if (load_has && apply_point) begin
      div_d         = load_val;
      div_pending_d = 1'b0;
    end else if (Div_load) begin
      pend_div_d    = div_in_safe;
      div_pending_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q       <= IDLE;
      count_q       <= '0;
      tick_q        <= 1'b0;
      div_q         <= RESET_DIV;
      pend_div_q    <= RESET_DIV;
      div_pending_q <= 1'b0;
      mode_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      tick_q        <= tick_d;
      div_q         <= div_d;
      pend_div_q    <= pend_div_d;
      div_pending_q <= div_pending_d;
      mode_q        <= mode_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign Tick        = tick_q;
  assign Count       = count_q;
  assign Busy        = (state_q == RUN);
  assign Done        = (state_q == DONE);
  assign Div_pending = div_pending_q;

endmodule

// File: tb/tb_tick_divider.sv
`timescale 1ns/1ps
// Self-checking bench for tick_divider. The DUT runs with a small clock
// frequency, so its derived reset divisor is CLK_HZ/100 = 10 cycles.
module tb_tick_divider;

  localparam int W           = 26;
  localparam int TB_CLK_HZ   = 1000;
  localparam int EXP_DEF_DIV = TB_CLK_HZ / 100;

  logic         Clock = 1'b0;
  logic         Resetn;
  logic         En;
  logic         Start;
  logic         Stop;
  logic         Mode;
  logic [W-1:0] Div_in;
  logic         Div_load;
  logic         Tick;
  logic [W-1:0] Count;
  logic         Busy;
  logic         Done;
  logic         Div_pending;

  int n_cmp = 0;
  int n_err = 0;

  tick_divider #(
    .CLK_HZ (TB_CLK_HZ),
    .WIDTH  (W)
  ) dut (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .En          (En),
    .Start       (Start),
    .Stop        (Stop),
    .Mode        (Mode),
    .Div_in      (Div_in),
    .Div_load    (Div_load),
    .Tick        (Tick),
    .Count       (Count),
    .Busy        (Busy),
    .Done        (Done),
    .Div_pending (Div_pending)
  );

  always #5 Clock = ~Clock;

  // Observed outputs packed as {tick, busy, done, pending, count}.
  logic [W+3:0] obs;
  assign obs = {Tick, Busy, Done, Div_pending, Count};

  function automatic logic [W+3:0] expv(bit t, bit b, bit d, bit p, int c);
    return {t, b, d, p, W'(c)};
  endfunction

  // Advance one clock and settle just after the edge.
  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic go_idle();
    Stop = 1'b1; cyc(); Stop = 1'b0;
  endtask

  task automatic load_div(int d);
    Div_in = W'(d); Div_load = 1'b1; cyc(); Div_load = 1'b0;
  endtask

  task automatic start_run(bit m);
    Mode = m; Start = 1'b1; cyc(); Start = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [W+3:0] e;
    // Reset beats a simultaneous Start and Div_load.
    Resetn = 1'b0; Start = 1'b1; Div_in = W'(3); Div_load = 1'b1; Mode = 1'b1; En = 1'b1;
    cyc(); cyc();
    e = expv(0, 0, 0, 0, 0);
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL reset_hold: got %h expected %h", obs, e); end
    Resetn = 1'b1; Start = 1'b0; Div_load = 1'b0; Mode = 1'b0;
    cyc();
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL reset_release: got %h expected %h", obs, e); end
    // The divisor must be the default, not the 3 offered during reset.
    start_run(1'b0);
    for (int k = 1; k <= 2 * EXP_DEF_DIV; k++) begin
      cyc();
      e = expv((k % EXP_DEF_DIV) == 0, 1, 0, 0, k % EXP_DEF_DIV);
      n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL reset_default_div[%0d]: got %h expected %h", k, obs, e); end
    end
    $display("test_reset complete");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_periodic();
    logic [W+3:0] e;
    go_idle();
    load_div(4);
    En = 1'b1;
    start_run(1'b0);
    e = expv(0, 1, 0, 0, 0);
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL periodic_start: got %h expected %h", obs, e); end
    for (int k = 1; k <= 12; k++) begin
      cyc();
      e = expv((k % 4) == 0, 1, 0, 0, k % 4);
      n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL periodic[%0d]: got %h expected %h", k, obs, e); end
    end
    $display("test_periodic complete");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_oneshot();
    logic [W+3:0] e;
    go_idle();
    load_div(5);
    En = 1'b1;
    for (int run = 0; run < 2; run++) begin
      start_run(1'b1);
      e = expv(0, 1, 0, 0, 0);
      n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL oneshot_start[%0d]: got %h expected %h", run, obs, e); end
      for (int k = 1; k <= 8; k++) begin
        cyc();
        if (k < 5)       e = expv(0, 1, 0, 0, k);
        else if (k == 5) e = expv(1, 0, 1, 0, 0);
        else             e = expv(0, 0, 1, 0, 0);
        n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL oneshot[%0d][%0d]: got %h expected %h", run, k, obs, e); end
      end
    end
    $display("test_oneshot complete");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_div_pending();
    logic [W+3:0] e;
    go_idle();
    load_div(10);
    En = 1'b1;
    start_run(1'b0);
    for (int k = 1; k <= 4; k++) cyc();
    // Count reads 4 here. Load a new divisor in mid-period.
    Div_in = W'(3); Div_load = 1'b1; cyc(); Div_load = 1'b0;
    for (int k = 5; k <= 10; k++) begin
      if (k > 5) cyc();
      e = (k == 10) ? expv(1, 1, 0, 0, 0) : expv(0, 1, 0, 1, k);
      n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL pending_old_period[%0d]: got %h expected %h", k, obs, e); end
    end
    for (int j = 1; j <= 9; j++) begin
      cyc();
      e = expv((j % 3) == 0, 1, 0, 0, j % 3);
      n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL pending_new_period[%0d]: got %h expected %h", j, obs, e); end
    end
    $display("test_div_pending complete");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_en_freeze();
    logic [W+3:0] e;
    go_idle();
    load_div(6);
    En = 1'b1;
    start_run(1'b0);
    cyc(); cyc();
    En = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      e = expv(0, 1, 0, 0, 2);
      n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL en_frozen[%0d]: got %h expected %h", k, obs, e); end
    end
    En = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      cyc();
      e = expv(j == 4, 1, 0, 0, (2 + j) % 6);
      n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL en_resume[%0d]: got %h expected %h", j, obs, e); end
    end
    $display("test_en_freeze complete");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_start_stop();
    logic [W+3:0] e;
    go_idle();
    load_div(8);
    En = 1'b1;
    start_run(1'b0);
    cyc(); cyc(); cyc();
    Start = 1'b1; Stop = 1'b1; cyc(); Start = 1'b0; Stop = 1'b0;
    e = expv(0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) cyc();
      n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL start_stop_same[%0d]: got %h expected %h", k, obs, e); end
    end
    // Stop also leaves DONE.
    load_div(2);
    start_run(1'b1);
    cyc(); cyc();
    e = expv(1, 0, 1, 0, 0);
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL reach_done: got %h expected %h", obs, e); end
    go_idle();
    e = expv(0, 0, 0, 0, 0);
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL stop_from_done: got %h expected %h", obs, e); end
    $display("test_start_stop complete");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_div_zero();
    logic [W+3:0] e;
    go_idle();
    load_div(0);
    En = 1'b1;
    start_run(1'b0);
    for (int k = 1; k <= 5; k++) begin
      cyc();
      e = expv(1, 1, 0, 0, 0);
      n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL div_zero[%0d]: got %h expected %h", k, obs, e); end
    end
    $display("test_div_zero complete");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_midrun();
    logic [W+3:0] e;
    go_idle();
    load_div(7);
    En = 1'b1;
    start_run(1'b0);
    cyc(); cyc(); cyc();
    Div_in = W'(2); Div_load = 1'b1; cyc(); Div_load = 1'b0;
    e = expv(0, 1, 0, 1, 4);
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL midrun_pending: got %h expected %h", obs, e); end
    Resetn = 1'b0; cyc(); Resetn = 1'b1;
    e = expv(0, 0, 0, 0, 0);
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL midrun_reset: got %h expected %h", obs, e); end
    start_run(1'b0);
    for (int k = 1; k <= EXP_DEF_DIV; k++) begin
      cyc();
      e = expv(k == EXP_DEF_DIV, 1, 0, 0, k % EXP_DEF_DIV);
      n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL midrun_default_div[%0d]: got %h expected %h", k, obs, e); end
    end
    $display("test_reset_midrun complete");
  endtask

  // ---------------------------------------------------------------------------
  // Randomised runs against an enabled-cycle-count model. A period ends
  // whenever the number of enabled cycles since the last Start is a multiple
  // of the divisor.
  task automatic test_random();
    logic [W+3:0] e;
    int  div;
    int  k;
    bit  active, done, oneshot, st, sp, m, en, t;
    for (int seg = 0; seg < 8; seg++) begin
      go_idle();
      div = $urandom_range(1, 12);
      load_div(div);
      active = 0; done = 0; oneshot = 0; k = 0;
      for (int c = 0; c < 80; c++) begin
        st = (c == 0) || ($urandom_range(0, 24) == 0);
        sp = ($urandom_range(0, 39) == 0);
        m  = $urandom_range(0, 1);
        en = ($urandom_range(0, 3) != 0);
        Start = st; Stop = sp; Mode = m; En = en;
        cyc();
        Start = 1'b0; Stop = 1'b0;
        t = 0;
        if (sp) begin
          active = 0; done = 0; k = 0;
        end else if (st) begin
          active = 1; done = 0; k = 0; oneshot = m;
        end else if (active && en) begin
          k++;
          if ((k % div) == 0) begin
            t = 1;
            if (oneshot) begin active = 0; done = 1; end
          end
        end
        e = expv(t, active, done, 0, active ? (k % div) : 0);
        n_cmp++;
        if (obs !== e) begin
          n_err++;
          $display("FAIL random[%0d][%0d] div=%0d: got %h expected %h", seg, c, div, obs, e);
        end
      end
    end
    En = 1'b1;
    $display("test_random complete");
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    Resetn = 1'b0; En = 1'b0; Start = 1'b0; Stop = 1'b0; Mode = 1'b0;
    Div_in = '0; Div_load = 1'b0;
    test_reset();
    test_periodic();
    test_oneshot();
    test_div_pending();
    test_en_freeze();
    test_start_stop();
    test_div_zero();
    test_reset_midrun();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
